// File: rtl/riscv_imm_pkg.sv
// Immediate-format codes and datapath width check.
// Shared by imm_decode, imm_gen_pipe and the control decoder.
package riscv_imm_pkg;

  localparam logic [2:0] IMM_R  = 3'd0;
  localparam logic [2:0] IMM_I  = 3'd1;
  localparam logic [2:0] IMM_S  = 3'd2;
  localparam logic [2:0] IMM_B  = 3'd3;
  localparam logic [2:0] IMM_U  = 3'd4;
  localparam logic [2:0] IMM_J  = 3'd5;
  localparam logic [2:0] IMM_CI = 3'd6;
  localparam logic [2:0] IMM_CJ = 3'd7;

  function automatic bit xlen_ok(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction and sign extension to XLEN.
// Compressed CI/CJ formats only exist when IMM_GEN_RVC_EN is defined.
module imm_decode
  import riscv_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic signed [31:0] raw;
  logic               unused_opc;

  assign unused_opc = ^instr[6:0];

  always_comb begin
    raw     = '0;
    illegal = 1'b0;
    unique case (imm_src)
      IMM_R: raw = '0;
      IMM_I: raw = {{20{instr[31]}}, instr[31:20]};
      IMM_S: raw = {{20{instr[31]}}, instr[31:25],
                    instr[11:7]};
      IMM_B: raw = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
      IMM_U: raw = {instr[31:12], 12'b0};
      IMM_J: raw = {{11{instr[31]}}, instr[31],
                    instr[19:12], instr[20],
                    instr[30:21], 1'b0};
`ifdef IMM_GEN_RVC_EN
      IMM_CI: raw = {{26{instr[12]}}, instr[12],
                     instr[6:2]};
      IMM_CJ: raw = {{20{instr[12]}}, instr[12], instr[8],
                     instr[10:9], instr[6], instr[7],
                     instr[2], instr[11], instr[5:3], 1'b0};
`else
      IMM_CI, IMM_CJ: illegal = 1'b1;
`endif
      default: illegal = 1'b1;
    endcase
  end

  // Signed source, so the size cast sign-fills the upper word on RV64.
  assign imm = XLEN'(raw);

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: output register plus skid register.
// Optional compressed formats under IMM_GEN_RVC_EN.
module imm_gen_pipe
  import riscv_imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      Instr,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  ExtImm,
  output logic [TAG_W-1:0] out_tag,
  output logic             Illegal
);

  if (!xlen_ok(XLEN)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
    logic             valid;
  } ent_t;

  ent_t            or_q;
  ent_t            sr_q;
  ent_t            nxt;
  logic [XLEN-1:0] dec_imm;
  logic            dec_ill;
  logic            acc;
  logic            drain;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr   (Instr),
    .imm_src (ImmSrc),
    .imm     (dec_imm),
    .illegal (dec_ill)
  );

  assign nxt = '{imm: dec_imm, tag: in_tag,
                 illegal: dec_ill, valid: 1'b1};

  assign in_ready = !sr_q.valid;
  assign acc      = in_valid && in_ready;
  assign drain    = out_ready && or_q.valid;

  // SR full implies in_ready=0, so a refill from SR never races an accept.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      or_q <= '0;
      sr_q <= '0;
    end else if (drain && sr_q.valid) begin
      or_q <= sr_q;
      sr_q <= '0;
    end else if (acc && (!or_q.valid || out_ready)) begin
      or_q <= nxt;
    end else if (acc) begin
      sr_q <= nxt;
    end else if (drain) begin
      or_q <= '0;
    end
  end

  assign out_valid = or_q.valid;
  assign ExtImm    = or_q.imm;
  assign out_tag   = or_q.tag;
  assign Illegal   = or_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed vectors, backpressure,
// reset and randomized traffic against a queue-based reference model.
module tb_imm_gen_pipe;

  localparam int XLEN  = 32;
  localparam int TAG_W = 8;

  logic             CLK;
  logic             Reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      Instr;
  logic [2:0]       ImmSrc;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  ExtImm;
  logic [TAG_W-1:0] out_tag;
  logic             Illegal;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } exp_t;

  exp_t q[$];

  imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Instr     (Instr),
    .ImmSrc    (ImmSrc),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ExtImm    (ExtImm),
    .out_tag   (out_tag),
    .Illegal   (Illegal)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: value of each immediate computed arithmetically from its
  // field weights; returns {illegal, 64-bit value}.
  function automatic logic [64:0] ref_imm(input logic [31:0] w,
                                          input logic [2:0] src);
    longint v;
    logic   ill;
    bit     rvc;
`ifdef IMM_GEN_RVC_EN
    rvc = 1'b1;
`else
    rvc = 1'b0;
`endif
    v   = 0;
    ill = 1'b0;
    case (src)
      3'd0: v = 0;
      3'd1: v = longint'($signed(w)) >>> 20;
      3'd2: v = (longint'($signed(w)) >>> 25) * 32
                + longint'(w[11:7]);
      3'd3: v = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
                + longint'(w[11:8]) * 2 - (w[31] ? 4096 : 0);
      3'd4: v = longint'($signed(w & 32'hFFFF_F000));
      3'd5: v = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
                + longint'(w[30:21]) * 2 - (w[31] ? 1048576 : 0);
      3'd6: begin
        if (rvc) v = longint'(w[6:2]) - (w[12] ? 32 : 0);
        else ill = 1'b1;
      end
      default: begin
        if (rvc)
          v = longint'(w[8]) * 1024 + longint'(w[10:9]) * 256
              + longint'(w[6]) * 128 + longint'(w[7]) * 64
              + longint'(w[2]) * 32 + longint'(w[11]) * 16
              + longint'(w[5:3]) * 2 - (w[12] ? 2048 : 0);
        else ill = 1'b1;
      end
    endcase
    return {ill, 64'(v)};
  endfunction

  task automatic idle();
    in_valid  = 1'b0;
    Instr     = '0;
    ImmSrc    = '0;
    in_tag    = '0;
  endtask

  task automatic test_reset();
    Reset     = 1'b1;
    out_ready = 1'b0;
    idle();
    in_valid  = 1'b1;
    Instr     = 32'hFFF0_0093;
    ImmSrc    = 3'd1;
    in_tag    = 8'h55;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
    idle();
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || ExtImm !== '0
        || out_tag !== '0 || Illegal !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: ov=%b ir=%b imm=%h tag=%h ill=%b want 0 1 0 0 0",
               out_valid, in_ready, ExtImm, out_tag, Illegal);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] vi [6];
    logic [2:0]  vs [6];
    logic [63:0] ve [6];
    logic        vl [6];
    logic [63:0] e;
    vi[0] = 32'hFFF0_0093; vs[0] = 3'd1; ve[0] = 64'hFFFF_FFFF_FFFF_FFFF; vl[0] = 0;
    vi[1] = 32'hFE00_0EE3; vs[1] = 3'd3; ve[1] = 64'hFFFF_FFFF_FFFF_FFFC; vl[1] = 0;
    vi[2] = 32'h0010_006F; vs[2] = 3'd5; ve[2] = 64'h0000_0000_0000_0800; vl[2] = 0;
    vi[3] = 32'h8000_00B7; vs[3] = 3'd4; ve[3] = 64'hFFFF_FFFF_8000_0000; vl[3] = 0;
    vi[4] = 32'hFFFF_FFFF; vs[4] = 3'd0; ve[4] = 64'h0;                   vl[4] = 0;
`ifdef IMM_GEN_RVC_EN
    vi[5] = 32'h0000_107D; vs[5] = 3'd6; ve[5] = 64'hFFFF_FFFF_FFFF_FFFF; vl[5] = 0;
`else
    vi[5] = 32'h0000_107D; vs[5] = 3'd6; ve[5] = 64'h0;                   vl[5] = 1;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      in_valid = 1'b1;
      Instr    = vi[i];
      ImmSrc   = vs[i];
      in_tag   = 8'(i + 16);
      @(negedge CLK);
      idle();
      #1;
      e = ve[i];
      n_cmp++;
      if (out_valid !== 1'b1 || ExtImm !== e[XLEN-1:0]
          || Illegal !== vl[i] || out_tag !== 8'(i + 16)) begin
        n_err++;
        $display("FAIL vector%0d: ov=%b imm=%h ill=%b tag=%h want 1 %h %b %h",
                 i, out_valid, ExtImm, Illegal, out_tag,
                 e[XLEN-1:0], vl[i], 8'(i + 16));
      end
    end
    @(negedge CLK);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL vec_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [TAG_W-1:0] want [5];
    logic             wrdy [5];
    @(negedge CLK);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    Instr     = 32'h0010_0093;
    ImmSrc    = 3'd1;
    in_tag    = 8'd1;
    @(negedge CLK);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_tag !== 8'd1) begin
      n_err++;
      $display("FAIL bp_tag1: ir=%b ov=%b tag=%0d want 1 1 1",
               in_ready, out_valid, out_tag);
    end
    in_tag = 8'd2;
    @(negedge CLK);
    in_tag = 8'd3;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 8'd1
          || ExtImm !== XLEN'(1)) begin
        n_err++;
        $display("FAIL bp_stall%0d: ir=%b ov=%b tag=%0d imm=%h want 0 1 1 1",
                 c, in_ready, out_valid, out_tag, ExtImm);
      end
      @(negedge CLK);
    end
    out_ready = 1'b1;
    want[0] = 8'd1; wrdy[0] = 1'b0;
    want[1] = 8'd2; wrdy[1] = 1'b1;
    want[2] = 8'd3; wrdy[2] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_tag !== want[c] || in_ready !== wrdy[c]) begin
        n_err++;
        $display("FAIL bp_drain%0d: ov=%b tag=%0d ir=%b want 1 %0d %b",
                 c, out_valid, out_tag, in_ready, want[c], wrdy[c]);
      end
      @(negedge CLK);
      if (c == 1) idle();
    end
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_empty: ov=%b ir=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge CLK);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    Instr     = 32'hFFF0_0093;
    ImmSrc    = 3'd1;
    in_tag    = 8'hA1;
    @(negedge CLK);
    in_tag = 8'hA2;
    @(negedge CLK);
    n_cmp++;
    if (in_ready !== 1'b0 || out_tag !== 8'hA1) begin
      n_err++;
      $display("FAIL mr_full: ir=%b tag=%h want 0 a1", in_ready, out_tag);
    end
    Reset  = 1'b1;
    in_tag = 8'hA3;
    @(negedge CLK);
    Reset = 1'b0;
    idle();
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || ExtImm !== '0
        || out_tag !== '0 || Illegal !== 1'b0) begin
      n_err++;
      $display("FAIL mr_cleared: ov=%b ir=%b imm=%h tag=%h ill=%b want 0 1 0 0 0",
               out_valid, in_ready, ExtImm, out_tag, Illegal);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL mr_stale%0d: ov=%b tag=%h want 0", c, out_valid, out_tag);
      end
    end
  endtask

  task automatic test_random();
    logic [64:0] r;
    exp_t        e;
    q.delete();
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      #1;
      n_cmp++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
        n_err++;
        $display("FAIL rnd_flags@%0d: ov=%b ir=%b occ=%0d", c,
                 out_valid, in_ready, q.size());
      end
      if (q.size() > 0 && out_valid === 1'b1) begin
        n_cmp++;
        if (ExtImm !== q[0].imm || out_tag !== q[0].tag
            || Illegal !== q[0].ill) begin
          n_err++;
          $display("FAIL rnd_data@%0d: imm=%h tag=%h ill=%b want %h %h %b",
                   c, ExtImm, out_tag, Illegal, q[0].imm, q[0].tag, q[0].ill);
        end
      end
      out_ready = ($urandom_range(0, 99) < 60);
      in_valid  = ($urandom_range(0, 99) < 70);
      Instr     = $urandom;
      ImmSrc    = 3'($urandom_range(0, 7));
      in_tag    = 8'($urandom);
      #1;
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) begin
        r     = ref_imm(Instr, ImmSrc);
        e.imm = r[XLEN-1:0];
        e.tag = in_tag;
        e.ill = r[64];
        q.push_back(e);
      end
    end
    @(negedge CLK);
    idle();
    out_ready = 1'b1;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rnd_final: ov=%b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
